// File: rtl/ws2812_frame_sequencer.sv
// Frame sequencer for the WS2812B chain: streams GRB pixels MSB-first as per-bit
// qmode codes to the NZR bitcode generator and closes each frame with a latch gap.
module ws2812_frame_sequencer #(
  parameter int NUM_LEDS    = 8,
  parameter int RESET_SLOTS = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [1:0]  qmode,
  output logic        startcoding,
  input  logic        bdone,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;
  localparam logic [1:0] ST_LATCH = 2'd3;

  localparam logic [1:0] Q_LOW     = 2'b10;
  localparam logic [7:0] LAST_LED  = 8'(NUM_LEDS);
  localparam logic [7:0] LAST_SLOT = 8'(RESET_SLOTS - 1);
  localparam logic [4:0] LAST_BIT  = 5'd23;

  logic [1:0]  state_reg, state_next;
  logic [23:0] shift_reg, shift_next;
  logic [23:0] buf_reg, buf_next;
  logic        buf_full_reg, buf_full_next;
  logic [4:0]  bit_idx_reg, bit_idx_next;
  logic [7:0]  led_cnt_reg, led_cnt_next;
  logic [7:0]  fetch_cnt_reg, fetch_cnt_next;
  logic [7:0]  slot_cnt_reg, slot_cnt_next;
  logic [1:0]  qmode_reg, qmode_next;
  logic        startcoding_reg, startcoding_next;
  logic        pix_ready_reg, pix_ready_next;
  logic        busy_reg, busy_next;
  logic        frame_done_reg, frame_done_next;
  logic        underrun_reg, underrun_next;
  logic        handshake;

  // pix_ready_reg is only ever high in LOAD/SEND, so it alone qualifies the handshake.
  assign handshake = pix_ready_reg & pix_valid;

  always_comb begin
    state_next       = state_reg;
    shift_next       = shift_reg;
    buf_next         = buf_reg;
    buf_full_next    = buf_full_reg;
    bit_idx_next     = bit_idx_reg;
    led_cnt_next     = led_cnt_reg;
    fetch_cnt_next   = fetch_cnt_reg;
    slot_cnt_next    = slot_cnt_reg;
    qmode_next       = qmode_reg;
    startcoding_next = startcoding_reg;
    frame_done_next  = 1'b0;
    underrun_next    = underrun_reg;

    case (state_reg)
      ST_IDLE: begin
        startcoding_next = 1'b1;
        qmode_next       = Q_LOW;
        if (start) begin
          state_next    = ST_LOAD;
          underrun_next = 1'b0;
        end
      end

      ST_LOAD: begin
        if (handshake) begin
          shift_next       = pix_data;
          qmode_next       = {1'b0, pix_data[23]};
          startcoding_next = 1'b0;
          bit_idx_next     = 5'd0;
          led_cnt_next     = 8'd1;
          fetch_cnt_next   = 8'd1;
          buf_full_next    = 1'b0;
          state_next       = ST_SEND;
        end
      end

      ST_SEND: begin
        if (handshake) begin
          buf_next       = pix_data;
          buf_full_next  = 1'b1;
          fetch_cnt_next = fetch_cnt_reg + 8'd1;
        end
        if (bdone) begin
          if (bit_idx_reg != LAST_BIT) begin
            // Rotate so the next bit to send is always at the top.
            bit_idx_next = bit_idx_reg + 5'd1;
            shift_next   = {shift_reg[22:0], shift_reg[23]};
            qmode_next   = {1'b0, shift_reg[22]};
          end else if (led_cnt_reg == LAST_LED) begin
            qmode_next    = Q_LOW;
            slot_cnt_next = 8'd0;
            state_next    = ST_LATCH;
          end else if (buf_full_reg) begin
            shift_next    = buf_reg;
            buf_full_next = 1'b0;
            led_cnt_next  = led_cnt_reg + 8'd1;
            bit_idx_next  = 5'd0;
            qmode_next    = {1'b0, buf_reg[23]};
          end else if (handshake) begin
            // Late pixel arriving on the boundary edge goes straight to the shifter.
            shift_next    = pix_data;
            buf_full_next = 1'b0;
            led_cnt_next  = led_cnt_reg + 8'd1;
            bit_idx_next  = 5'd0;
            qmode_next    = {1'b0, pix_data[23]};
          end else begin
            underrun_next = 1'b1;
            qmode_next    = Q_LOW;
            slot_cnt_next = 8'd0;
            state_next    = ST_LATCH;
          end
        end
      end

      default: begin
        qmode_next = Q_LOW;
        if (bdone) begin
          if (slot_cnt_reg == LAST_SLOT) begin
            startcoding_next = 1'b1;
            frame_done_next  = 1'b1;
            state_next       = ST_IDLE;
          end else begin
            slot_cnt_next = slot_cnt_reg + 8'd1;
          end
        end
      end
    endcase

    pix_ready_next = (state_next == ST_LOAD) ||
                     ((state_next == ST_SEND) && !buf_full_next && (fetch_cnt_next < LAST_LED));
    busy_next      = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      shift_reg       <= '0;
      buf_reg         <= '0;
      buf_full_reg    <= 1'b0;
      bit_idx_reg     <= '0;
      led_cnt_reg     <= '0;
      fetch_cnt_reg   <= '0;
      slot_cnt_reg    <= '0;
      qmode_reg       <= Q_LOW;
      startcoding_reg <= 1'b1;
      pix_ready_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      frame_done_reg  <= 1'b0;
      underrun_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      shift_reg       <= shift_next;
      buf_reg         <= buf_next;
      buf_full_reg    <= buf_full_next;
      bit_idx_reg     <= bit_idx_next;
      led_cnt_reg     <= led_cnt_next;
      fetch_cnt_reg   <= fetch_cnt_next;
      slot_cnt_reg    <= slot_cnt_next;
      qmode_reg       <= qmode_next;
      startcoding_reg <= startcoding_next;
      pix_ready_reg   <= pix_ready_next;
      busy_reg        <= busy_next;
      frame_done_reg  <= frame_done_next;
      underrun_reg    <= underrun_next;
    end
  end

  assign pix_ready   = pix_ready_reg;
  assign qmode       = qmode_reg;
  assign startcoding = startcoding_reg;
  assign busy        = busy_reg;
  assign frame_done  = frame_done_reg;
  assign underrun    = underrun_reg;

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Bench for ws2812_frame_sequencer: a 128-cycle bitcode generator model supplies bdone,
// and each frame's qmode stream, length and handshakes are compared with a pixel-level model.
module tb_ws2812_frame_sequencer;

  localparam int NUM_LEDS    = 2;
  localparam int RESET_SLOTS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [23:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [1:0]  qmode;
  logic        startcoding;
  logic        bdone;
  logic        busy;
  logic        frame_done;
  logic        underrun;

  always #5 clk = ~clk;

  ws2812_frame_sequencer #(
    .NUM_LEDS   (NUM_LEDS),
    .RESET_SLOTS(RESET_SLOTS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .qmode      (qmode),
    .startcoding(startcoding),
    .bdone      (bdone),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  // Generator model: counter held at zero by startcoding, bdone in the slot's last cycle.
  logic [6:0] gen_cnt = '0;
  always @(posedge clk) begin
    if (reset || startcoding) gen_cnt <= '0;
    else                      gen_cnt <= gen_cnt + 7'd1;
  end
  assign bdone = !startcoding && (gen_cnt == 7'd127);

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: edge-time handshake/bdone, then the qmode each such edge produced.
  logic [1:0] obs_q[$];
  int cyc = 0, hs_cnt = 0, hs_time = 0, done_time = 0;
  logic mon_hs, mon_load, mon_bd;
  always @(posedge clk) begin
    mon_hs   = pix_ready && pix_valid;
    mon_load = mon_hs && startcoding;
    mon_bd   = bdone;
    #1;
    cyc++;
    if (mon_hs) hs_cnt++;
    if (mon_load) hs_time = cyc;
    if (mon_load || mon_bd) obs_q.push_back(qmode);
    if (frame_done) done_time = cyc;
  end

  // mode 0: pixel 1 always valid; 1: random delay; 2: valid in bit-23 bdone cycle (bypass);
  // 3: valid one cycle after bit-23 bdone (underrun).
  task automatic run_frame(input int mode, input logic [23:0] p0, input logic [23:0] p1,
                           input bit mid_start);
    logic [1:0]  exp_q[$];
    logic [23:0] pix[2];
    logic [1:0]  got;
    int npix, guard, nb;
    obs_q.delete();
    hs_cnt    = 0;
    start     = 1'b1;
    pix_data  = p0;
    pix_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("done_pulse", int'(frame_done), 0);
    check_eq("busy_load", int'(busy), 1);
    check_eq("ready_load", int'(pix_ready), 1);
    check_eq("underrun_clr", int'(underrun), 0);
    @(negedge clk);
    case (mode)
      0: pix_data = p1;
      1: begin
        pix_valid = 1'b0;
        repeat ($urandom_range(1, 2500)) @(negedge clk);
        pix_data  = p1;
        pix_valid = 1'b1;
      end
      default: begin
        pix_valid = 1'b0;
        nb = 0;
        guard = 0;
        while (nb < 24 && guard < 5000) begin
          if (bdone) nb++;
          if (nb < 24) begin
            @(negedge clk);
            guard++;
          end
        end
        check_eq("bit23_wait", nb, 24);
        if (mode == 3) @(negedge clk);
        pix_data  = p1;
        pix_valid = 1'b1;
      end
    endcase
    guard = 0;
    while (!frame_done && guard < 20000) begin
      if (hs_cnt >= 2) begin
        if (mode == 0) pix_data = 24'($urandom);
        else           pix_valid = 1'b0;
      end
      if (mid_start) start = (guard == 300);
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    check_eq("frame_done_seen", int'(frame_done), 1);

    npix = (mode == 3) ? 1 : 2;
    check_eq("frame_len", done_time - hs_time, (24 * npix + RESET_SLOTS) * 128);
    check_eq("handshakes", hs_cnt, npix);
    check_eq("underrun_flag", int'(underrun), (mode == 3) ? 1 : 0);
    check_eq("idle_busy", int'(busy), 0);
    check_eq("idle_startcoding", int'(startcoding), 1);

    pix[0] = p0;
    pix[1] = p1;
    for (int k = 0; k < npix; k++)
      for (int b = 23; b >= 0; b--) exp_q.push_back({1'b0, pix[k][b]});
    repeat (RESET_SLOTS + 1) exp_q.push_back(2'b10);
    check_eq("stream_len", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 2'b11;
      check_eq($sformatf("qmode[%0d]", i), int'(got), int'(exp_q[i]));
    end
    $display("frame mode=%0d p0=%06h p1=%06h len=%0d hs=%0d underrun=%0b", mode, p0, p1,
             done_time - hs_time, hs_cnt, underrun);
  endtask

  task automatic reset_mid_frame();
    int nb, guard;
    nb = 0;
    guard = 0;
    start     = 1'b1;
    pix_data  = 24'($urandom);
    pix_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (nb < 30 && guard < 10000) begin
      if (bdone) nb++;
      if (pix_ready) pix_data = 24'($urandom);
      @(negedge clk);
      guard++;
    end
    check_eq("slot30_reach", nb, 30);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_qmode", int'(qmode), 2);
    check_eq("rst_startcoding", int'(startcoding), 1);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_pix_ready", int'(pix_ready), 0);
    check_eq("rst_frame_done", int'(frame_done), 0);
    reset     = 1'b0;
    pix_valid = 1'b0;
    repeat (3) @(negedge clk);
    $display("reset at slot %0d: qmode=%0b startcoding=%0b busy=%0b", nb, qmode, startcoding, busy);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("init_qmode", int'(qmode), 2);
    check_eq("init_startcoding", int'(startcoding), 1);
    check_eq("init_pix_ready", int'(pix_ready), 0);
    check_eq("init_busy", int'(busy), 0);
    check_eq("init_frame_done", int'(frame_done), 0);
    check_eq("init_underrun", int'(underrun), 0);

    run_frame(0, 24'hA50000, 24'h0000FF, 1'b0);
    run_frame(3, 24'($urandom), 24'($urandom), 1'b0);
    run_frame(0, 24'($urandom), 24'($urandom), 1'b1);
    run_frame(2, 24'($urandom), 24'($urandom), 1'b0);
    run_frame(1, 24'($urandom), 24'($urandom), 1'b0);
    run_frame(3, 24'($urandom), 24'($urandom), 1'b0);
    run_frame(1, 24'($urandom), 24'($urandom), 1'b1);
    run_frame(2, 24'($urandom), 24'($urandom), 1'b0);
    pix_valid = 1'b0;
    repeat (4) @(negedge clk);

    reset_mid_frame();
    run_frame(0, 24'($urandom), 24'($urandom), 1'b0);
    pix_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ws2812_frame_sequencer.md
# ws2812_frame_sequencer

Frame-level sequencer that sits directly upstream of the NZR bitcode generator in the WS2812B LED chain. It accepts 24-bit GRB pixels over a valid/ready handshake and serialises them MSB-first as per-bit `qmode` codes, advancing on the generator's `bdone`. It closes every frame with a low latch period of whole bitcode slots. It drives `startcoding` so that bit timing in the generator is aligned to the first bit of each frame.

## Interface
- `NUM_LEDS`, 8: pixels per frame (1..255).
- `RESET_SLOTS`, 40: 1.28 µs bitcode slots of solid low after the last bit (40 slots = 51.2 µs, which is ≥ the 50 µs WS2812B latch time; range 1..255).

- `clk` input 1: 100 MHz clock.
- `reset` input 1: synchronous, active-high.
- `start` input 1: one-cycle request to send one frame; honoured only in IDLE.
- `pix_data` input 24: GRB pixel; bit 23 (G7) is sent first.
- `pix_valid` input 1: `pix_data` is valid.
- `pix_ready` output 1: sequencer accepts `pix_data` this cycle.
- `qmode` output 2: code to the generator: 00 = "0", 01 = "1", 10 = low. 11 is never driven.
- `startcoding` output 1: holds the generator counter at zero.
- `bdone` input 1: generator bitcode complete (high in the slot's last cycle).
- `busy` output 1: high whenever the sequencer is not in IDLE.
- `frame_done` output 1: one-cycle pulse when the latch period ends.
- `underrun` output 1: sticky flag. Set when a pixel is missing at a pixel boundary; cleared when the next `start` is accepted.

## Operation
- All outputs are registered. Reset values: `qmode`=10, `startcoding`=1, `pix_ready`=0, `busy`=0, `frame_done`=0, `underrun`=0. All counters and the buffer flag are reset to zero.
- State: shift register (24 bits), one-entry prefetch buffer with full flag, `bit_idx` (0..23), `led_cnt` (pixels started), `fetch_cnt` (pixels accepted), `slot_cnt`.
- IDLE: `startcoding`=1, `qmode`=10. `bdone` is ignored. `start` → LOAD and clears `underrun`.
- LOAD: `pix_ready`=1. On handshake:
  - load the shift register;
  - set `qmode` = {0, `pix_data`[23]};
  - set `startcoding`=0, `bit_idx`=0, `led_cnt`=1, `fetch_cnt`=1;
  - go to SEND.
- SEND, `pix_ready` rule: `pix_ready` = buffer empty AND `fetch_cnt` < `NUM_LEDS`. A handshake fills the buffer and increments `fetch_cnt`.
- SEND, `bdone` with `bit_idx` < 23: `bit_idx`++ and `qmode` = {0, next bit}.
- SEND, `bdone` with `bit_idx` = 23, evaluated in this priority order:
  1. `led_cnt` = `NUM_LEDS`: `qmode`=10, `slot_cnt`=0, go to LATCH.
  2. Buffer full: move the buffer into the shift register, `led_cnt`++, `bit_idx`=0, `qmode` = {0, buf[23]}.
  3. Buffer empty, but a handshake occurs in the same cycle: the incoming pixel bypasses the buffer straight into the shift register. This is not an underrun.
  4. Otherwise: set `underrun`=1, `qmode`=10, go to LATCH. The remaining pixels are not fetched.
- LATCH: `qmode`=10 and `pix_ready`=0. Each `bdone` increments `slot_cnt`. On the `RESET_SLOTS`-th `bdone`: `startcoding`=1, `frame_done`=1 for one cycle, go to IDLE.
- `start` outside IDLE is ignored. `pix_valid` outside LOAD/SEND is ignored (no handshake).
- `reset` mid-frame: return to IDLE on the next edge. All outputs take their reset values (generator held, line low). The partial frame is abandoned and the buffer is cleared.

## Timing
- The handshake in LOAD is taken at edge E. The generator counter is still held at E, so the first bit slot occupies the 128 cycles from E+1 to E+128.
- `qmode` changes only at the `bdone` edge, i.e. together with the generator's 127→0 rollover. This gives zero-cycle gaps between slots.
- Frame length, from the LOAD handshake to `frame_done`: (24·`NUM_LEDS` + `RESET_SLOTS`)·128 cycles. With defaults: 29696 cycles.
- `frame_done` coincides with the first IDLE cycle. A `start` in that same cycle is accepted.
- Prefetch window: after each pixel move, upstream has 23·128 + 127 cycles to present the next pixel before an underrun occurs.
- Widths: `bit_idx` is 5 bits. `led_cnt`, `fetch_cnt` and `slot_cnt` are 8 bits. No wrap is permitted within the parameter range.

## Test plan
All scenarios use the real bitcode generator as the `bdone` source.

- `NUM_LEDS`=2, `RESET_SLOTS`=2, pixels 0xA50000 and 0x0000FF always valid:
  - `qmode` sequence is 01,00,01,00,00,01,00,01, then 16×00, then 16×00, then 8×01, then 2×10;
  - `frame_done` occurs 6400 cycles after the LOAD handshake;
  - `pix_ready` pulses exactly twice.
- Decoded output line: "0" bits are high for 40 cycles and "1" bits for 90 cycles, every slot is 128 cycles, and there are no glitches at pixel boundaries.
- Second pixel withheld until after bit 23 `bdone`: `underrun`=1, `qmode`=10 from that edge, `frame_done` follows `RESET_SLOTS`·128 cycles later. The next `start` clears `underrun`.
- Second pixel `pix_valid` rises in the same cycle as bit 23 `bdone`: bypass is taken, `underrun` stays 0, and the bit stream is continuous.
- `start` pulsed mid-SEND and `start` in the `frame_done` cycle: the first is ignored; the second begins a new frame with LOAD on the next cycle.
- `reset` asserted at slot 30 of frame 1: the next cycle shows `qmode`=10, `startcoding`=1, `busy`=0, `pix_ready`=0. A new `start` then sends a full, correct frame.
